// File: rtl/vga_pixel_stream_buffer_if.sv
`default_nettype none
// =============================================================================
// vga_pixel_stream_buffer_if : valid/ready pixel stream with start-of-frame tag (rev 1.0)
// =============================================================================
interface vga_pixel_stream_buffer_if #(
  parameter int CD = 12
);
  logic [CD-1:0] rgb;
  logic          sof;
  logic          valid;
  logic          ready;

  modport master (output rgb, output sof, output valid, input ready);
  modport slave  (input rgb, input sof, input valid, output ready);
endinterface
`default_nettype wire

// File: rtl/vga_pixel_stream_buffer.sv
`default_nettype none
// =============================================================================
// vga_pixel_stream_buffer : frame-aligning pixel FIFO ahead of the VGA sync circuit (rev 1.0)
// =============================================================================
module vga_pixel_stream_buffer #(
  parameter int          CD    = 12,
  parameter int          DEPTH = 16,
  parameter int          HD    = 640,
  parameter int          VD    = 480,
  parameter int          HT    = 800,
  parameter int          VT    = 525,
  parameter logic [CD-1:0] FILL = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  vga_pixel_stream_buffer_if.slave      s,
  input  logic [10:0]                   hc,
  input  logic [10:0]                   vc,
  input  logic                          pix_en,
  output logic [CD-1:0]                 vga_si_rgb,
  output logic                          locked,
  output logic                          underflow,
  output logic                          sync_err,
  input  logic                          clr_status
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [10:0]   c_ht_last = 11'(HT - 1);
  localparam logic [10:0]   c_vt_last = 11'(VT - 1);
  localparam logic [10:0]   c_hd      = 11'(HD);
  localparam logic [10:0]   c_vd      = 11'(VD);
  localparam logic [AW:0]   c_full    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   c_cnt_one = (AW+1)'(1);
  localparam logic [AW-1:0] c_ptr_one = AW'(1);

  typedef enum logic [1:0] {
    ST_SEEK   = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  state_t        r_state, w_state_n;
  logic [CD:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic [CD-1:0] r_rgb, w_rgb_n;
  logic          r_locked, w_locked_n;
  logic          r_underflow, r_sync_err;
  logic          w_uf_set, w_se_set, w_pop, w_push, w_full, w_empty;
  logic [CD:0]   w_head;
  logic          w_head_sof, w_h_wrap, w_next_vis, w_next_org;
  logic [10:0]   w_nh, w_nv;

  // Ready is held low through the reset cycle even though the FIFO is combinationally empty
  assign w_full     = (r_count == c_full);
  assign w_empty    = (r_count == '0);
  assign s.ready    = !w_full && !reset;
  assign w_push     = s.valid && s.ready;
  assign w_head     = r_mem[r_rd_ptr];
  assign w_head_sof = w_head[CD];

  // Raster position the frame counter moves to on this pix_en
  assign w_h_wrap   = (hc == c_ht_last);
  assign w_nh       = w_h_wrap ? 11'd0 : hc + 11'd1;
  assign w_nv       = w_h_wrap ? ((vc == c_vt_last) ? 11'd0 : vc + 11'd1) : vc;
  assign w_next_vis = (w_nh < c_hd) && (w_nv < c_vd);
  assign w_next_org = (w_nh == 11'd0) && (w_nv == 11'd0);

  always_comb begin
    w_state_n  = r_state;
    w_rgb_n    = FILL;
    w_locked_n = r_locked;
    w_pop      = 1'b0;
    w_uf_set   = 1'b0;
    w_se_set   = 1'b0;
    case (r_state)
      ST_SEEK: begin
        w_locked_n = 1'b0;
        if (!w_empty) begin
          if (w_head_sof) w_state_n = ST_ALIGN;
          else            w_pop     = 1'b1;
        end
      end
      ST_ALIGN: begin
        if (pix_en && w_next_org && !w_empty && w_head_sof) begin
          w_pop      = 1'b1;
          w_rgb_n    = w_head[CD-1:0];
          w_locked_n = 1'b1;
          w_state_n  = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (pix_en) begin
          if (!w_next_vis) begin
            w_rgb_n = '0;
          end else if (w_empty) begin
            w_uf_set = 1'b1;
          end else if (w_next_org && !w_head_sof) begin
            w_se_set   = 1'b1;
            w_locked_n = 1'b0;
            w_state_n  = ST_SEEK;
          end else if (!w_next_org && w_head_sof) begin
            w_se_set   = 1'b1;
            w_locked_n = 1'b0;
            w_state_n  = ST_ALIGN;
          end else begin
            w_pop   = 1'b1;
            w_rgb_n = w_head[CD-1:0];
          end
        end
      end
      default: w_state_n = ST_SEEK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {s.sof, s.rgb};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_SEEK;
      r_rgb       <= FILL;
      r_locked    <= 1'b0;
      r_underflow <= 1'b0;
      r_sync_err  <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else begin
      r_state  <= w_state_n;
      r_locked <= w_locked_n;
      if (pix_en) r_rgb <= w_rgb_n;
      // A flag event outranks a simultaneous clear
      r_underflow <= w_uf_set | (r_underflow & ~clr_status);
      r_sync_err  <= w_se_set | (r_sync_err & ~clr_status);
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  assign vga_si_rgb = r_rgb;
  assign locked     = r_locked;
  assign underflow  = r_underflow;
  assign sync_err   = r_sync_err;

endmodule
`default_nettype wire
